// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU func codes, sequencer states and operand-need helpers
package alu_pkg;

  localparam int ALU_FUNC_W = 3;

  localparam logic [ALU_FUNC_W-1:0] FUNC_ADD    = 3'b000;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SUB    = 3'b001;
  localparam logic [ALU_FUNC_W-1:0] FUNC_NAND   = 3'b010;
  localparam logic [ALU_FUNC_W-1:0] FUNC_INC    = 3'b011;
  localparam logic [ALU_FUNC_W-1:0] FUNC_PASS_A = 3'b100;
  localparam logic [ALU_FUNC_W-1:0] FUNC_PASS_B = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD_A = 3'd1,
    ST_LD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_RESP = 3'd4
  } seq_state_t;

  // Codes 110 and 111 have no ALU operation behind them.
  function automatic logic func_legal(input logic [ALU_FUNC_W-1:0] func);
    return (func <= FUNC_PASS_B);
  endfunction

  // Every legal op except PASS_B reads the A latch.
  function automatic logic needs_a(input logic [ALU_FUNC_W-1:0] func);
    return func_legal(func) && (func != FUNC_PASS_B);
  endfunction

  // Two-operand ops plus PASS_B read the B latch.
  function automatic logic needs_b(input logic [ALU_FUNC_W-1:0] func);
    return (func == FUNC_ADD) || (func == FUNC_SUB) ||
           (func == FUNC_NAND) || (func == FUNC_PASS_B);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/operand/response sequencer driving the combinational ALU
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [FUNC_W-1:0] req_func,
  output logic              req_ready,
  input  logic              opnd_valid,
  input  logic [DATA_W-1:0] opnd_data,
  output logic              opnd_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_neg,
  output logic              rsp_err
);

  seq_state_t state, state_nxt;

  // Handshake outputs are pure state decodes so no input reaches an output combinationally.
  assign req_ready  = (state == ST_IDLE);
  assign opnd_ready = (state == ST_LD_A) || (state == ST_LD_B);
  assign rsp_valid  = (state == ST_RESP);

  // State register; reset abandons any partially collected operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: operand collection order follows the func's operand needs.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!func_legal(req_func)) begin
            state_nxt = ST_RESP;
          end else if (needs_a(req_func)) begin
            state_nxt = ST_LD_A;
          end else begin
            state_nxt = ST_LD_B;
          end
        end
      end
      ST_LD_A: begin
        if (opnd_valid) begin
          state_nxt = needs_b(alu_func) ? ST_LD_B : ST_EXEC;
        end
      end
      ST_LD_B: begin
        if (opnd_valid) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latches and result register; unloaded latches keep their previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_func <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b1;
      rsp_neg  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_func <= req_func;
            if (!func_legal(req_func)) begin
              rsp_data <= '0;
              rsp_zero <= 1'b1;
              rsp_neg  <= 1'b0;
              rsp_err  <= 1'b1;
            end
          end
        end
        ST_LD_A: begin
          if (opnd_valid) begin
            alu_a <= opnd_data;
          end
        end
        ST_LD_B: begin
          if (opnd_valid) begin
            alu_b <= opnd_data;
          end
        end
        ST_EXEC: begin
          rsp_data <= alu_out;
          rsp_zero <= (alu_out == '0);
          rsp_neg  <= alu_out[DATA_W-1];
          rsp_err  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  req_func;
  logic        req_ready;
  logic        opnd_valid;
  logic [31:0] opnd_data;
  logic        opnd_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_func;
  logic [31:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_neg;
  logic        rsp_err;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  int words;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(32), .FUNC_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_func   (req_func),
    .req_ready  (req_ready),
    .opnd_valid (opnd_valid),
    .opnd_data  (opnd_data),
    .opnd_ready (opnd_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg),
    .rsp_err    (rsp_err)
  );

  // Behavioural MY-P0 ALU.
  always_comb begin
    case (alu_func)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = ~(alu_a & alu_b);
      3'b011:  alu_out = alu_a + 32'd1;
      3'b100:  alu_out = alu_a;
      3'b101:  alu_out = alu_b;
      default: alu_out = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a request, feed words w0 then w1 whenever opnd_ready is high (after
  // 'stall' idle cycles per operand), and stop once rsp_valid rises.
  // lat counts clock edges after the accepting edge.
  task automatic do_op(input logic [2:0] f, input logic [31:0] w0, input logic [31:0] w1,
                       input int stall, output int lat_o, output int words_o);
    int st;
    logic consumed;
    st = 0;
    req_valid = 1'b1;
    req_func  = f;
    tick();
    req_valid = 1'b0;
    lat_o   = 0;
    words_o = 0;
    while (!rsp_valid && lat_o < 40) begin
      consumed = 1'b0;
      if (opnd_ready) begin
        if (st < stall) begin
          opnd_valid = 1'b0;
          st++;
        end else begin
          opnd_valid = 1'b1;
          opnd_data  = (words_o == 0) ? w0 : w1;
          consumed   = 1'b1;
        end
      end else begin
        opnd_valid = 1'b0;
      end
      tick();
      lat_o++;
      if (consumed) begin
        words_o++;
        st = 0;
      end
    end
    opnd_valid = 1'b0;
    check("rsp_valid_within_bound", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic ack_rsp;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("back_to_idle", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_func   = 3'b000;
    opnd_valid = 1'b0;
    opnd_data  = 32'h0;
    rsp_ready  = 1'b0;
    #12;
    check("rst_req_ready",  {31'b0, req_ready},  32'd1);
    check("rst_opnd_ready", {31'b0, opnd_ready}, 32'd0);
    check("rst_rsp_valid",  {31'b0, rsp_valid},  32'd0);
    check("rst_rsp_zero",   {31'b0, rsp_zero},   32'd1);
    check("rst_rsp_err",    {31'b0, rsp_err},    32'd0);
    check("rst_alu_a",      alu_a,               32'h0);
    check("rst_alu_func",   {29'b0, alu_func},   32'd0);
    check("rst_rsp_data",   rsp_data,            32'h0);
    rst_n = 1'b1;
    tick();

    // ADD 5 + 3
    do_op(3'b000, 32'h5, 32'h3, 0, lat, words);
    check("add_lat",   lat,      32'd3);
    check("add_words", words,    32'd2);
    check("add_data",  rsp_data, 32'h8);
    check("add_zero",  {31'b0, rsp_zero}, 32'd0);
    check("add_neg",   {31'b0, rsp_neg},  32'd0);
    check("add_err",   {31'b0, rsp_err},  32'd0);
    ack_rsp();

    // SUB 3 - 5 wraps negative
    do_op(3'b001, 32'h3, 32'h5, 0, lat, words);
    check("sub_data", rsp_data, 32'hFFFF_FFFE);
    check("sub_neg",  {31'b0, rsp_neg}, 32'd1);
    ack_rsp();

    // INC 0xFFFFFFFF wraps to zero, B latch untouched
    do_op(3'b011, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 0, lat, words);
    check("inc_lat",   lat,      32'd2);
    check("inc_words", words,    32'd1);
    check("inc_data",  rsp_data, 32'h0);
    check("inc_zero",  {31'b0, rsp_zero}, 32'd1);
    check("inc_b_kept", alu_b,   32'h5);
    ack_rsp();

    // PASS_B loads only B
    do_op(3'b101, 32'hDEAD_BEEF, 32'h1111_1111, 0, lat, words);
    check("passb_lat",   lat,      32'd2);
    check("passb_words", words,    32'd1);
    check("passb_data",  rsp_data, 32'hDEAD_BEEF);
    check("passb_neg",   {31'b0, rsp_neg}, 32'd1);
    check("passb_a_kept", alu_a,   32'hFFFF_FFFF);
    ack_rsp();

    // NAND all-ones gives zero
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, words);
    check("nand_data", rsp_data, 32'h0);
    check("nand_zero", {31'b0, rsp_zero}, 32'd1);
    ack_rsp();

    // PASS_A of the sign bit
    do_op(3'b100, 32'h8000_0000, 32'h0, 0, lat, words);
    check("passa_data", rsp_data, 32'h8000_0000);
    check("passa_neg",  {31'b0, rsp_neg}, 32'd1);
    check("passa_zero", {31'b0, rsp_zero}, 32'd0);
    ack_rsp();

    // Illegal 110: response on the very next edge, operands offered but ignored
    opnd_valid = 1'b1;
    opnd_data  = 32'h1234_5678;
    req_valid  = 1'b1;
    req_func   = 3'b110;
    tick();
    req_valid = 1'b0;
    check("ill_rsp_valid",  {31'b0, rsp_valid},  32'd1);
    check("ill_opnd_ready", {31'b0, opnd_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("ill_hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("ill_hold_err",   {31'b0, rsp_err},   32'd1);
      check("ill_hold_data",  rsp_data,           32'h0);
      check("ill_hold_zero",  {31'b0, rsp_zero},  32'd1);
      check("ill_hold_neg",   {31'b0, rsp_neg},   32'd0);
      check("ill_req_ready",  {31'b0, req_ready}, 32'd0);
      tick();
    end
    opnd_valid = 1'b0;
    check("ill_a_kept", alu_a, 32'h8000_0000);
    ack_rsp();

    // Illegal 111
    do_op(3'b111, 32'h0, 32'h0, 0, lat, words);
    check("ill7_lat", lat, 32'd0);
    check("ill7_err", {31'b0, rsp_err}, 32'd1);
    ack_rsp();

    // ADD with 3-cycle stalls on both operands
    do_op(3'b000, 32'h7, 32'h9, 3, lat, words);
    check("stall_lat",  lat,      32'd9);
    check("stall_data", rsp_data, 32'h10);
    check("stall_err",  {31'b0, rsp_err}, 32'd0);
    ack_rsp();

    // Async reset between operand A and B
    req_valid = 1'b1;
    req_func  = 3'b000;
    tick();
    req_valid  = 1'b0;
    opnd_valid = 1'b1;
    opnd_data  = 32'h55;
    tick();
    opnd_valid = 1'b0;
    check("mid_alu_a", alu_a, 32'h55);
    check("mid_opnd_ready", {31'b0, opnd_ready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid",  {31'b0, rsp_valid},  32'd0);
    check("arst_alu_a",      alu_a,               32'h0);
    check("arst_alu_func",   {29'b0, alu_func},   32'd0);
    check("arst_opnd_ready", {31'b0, opnd_ready}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("arst_req_ready", {31'b0, req_ready}, 32'd1);
    do_op(3'b000, 32'h1, 32'h1, 0, lat, words);
    check("post_rst_data", rsp_data, 32'h2);
    check("post_rst_lat",  lat,      32'd3);
    ack_rsp();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
